// File: rtl/div_272x16.sv
// Radix-2 restoring divider, one quotient bit per clock, MSB first.
// Optional quotient-overflow flag (quotient wider than 256 bits) under `DIV_Q_OVF_EN.
module div_272x16 #(
    parameter int DIVIDEND_W = 272,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  busy,
    output logic                  done
`ifdef DIV_Q_OVF_EN
    ,
    output logic                  q_ovf
`endif
);

    localparam int CNT_W    = $clog2(DIVIDEND_W + 1);
    localparam int QOVF_LSB = 256;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] shift_q, shift_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic                  dbz_q, dbz_d;
`ifdef DIV_Q_OVF_EN
    logic                  q_ovf_q, q_ovf_d;
`endif

    logic [DIVISOR_W:0]    r17;
    logic [DIVISOR_W-1:0]  diff;
    logic                  q_bit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
`ifdef DIV_Q_OVF_EN
        q_ovf_d = q_ovf_q;
`endif
        r17   = {rem_q, shift_q[DIVIDEND_W-1]};
        // Result always fits DIVISOR_W bits when r17 >= divisor, since the old remainder < divisor.
        diff  = r17[DIVISOR_W-1:0] - dvs_q;
        q_bit = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = dividend;
                    dvs_d   = divisor;
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
`ifdef DIV_Q_OVF_EN
                    q_ovf_d = 1'b0;
`endif
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend[DIVISOR_W-1:0];
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(DIVIDEND_W);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                shift_d = {shift_q[DIVIDEND_W-2:0], 1'b0};
                if (r17 >= {1'b0, dvs_q}) begin
                    rem_d = diff;
                    q_bit = 1'b1;
                end else begin
                    rem_d = r17[DIVISOR_W-1:0];
                end
                quot_d = {quot_q[DIVIDEND_W-2:0], q_bit};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
`ifdef DIV_Q_OVF_EN
                    q_ovf_d = |quot_d[DIVIDEND_W-1:QOVF_LSB];
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_Q_OVF_EN
            q_ovf_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
`ifdef DIV_Q_OVF_EN
            q_ovf_q <= q_ovf_d;
`endif
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
`ifdef DIV_Q_OVF_EN
    assign q_ovf       = q_ovf_q;
`endif

endmodule
